// File: rtl/output_pulser_pkg.sv
// Shared types and constants for the output pulser and its per-channel FSM.
package output_pulser_pkg;

  // Per-channel pulse state: waiting, driving the pulse, or holding off.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } pulse_state_t;

  // Width of the per-channel phase counter; covers PULSE_LEN/DEAD_LEN up to 255.
  localparam int PULSE_CW = 8;

  // Ceiling of the lost-request counter.
  localparam logic [15:0] LOST_MAX = 16'hFFFF;

endpackage

// File: rtl/output_pulser_channel.sv
// One output channel: a fixed-width pulse followed by a dead-time hold-off.
// A request arriving while the channel is busy is flagged as lost.
module pulse_channel
  import output_pulser_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int DEAD_LEN  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic q,
  output logic busy,
  output logic lost
);

  localparam logic [PULSE_CW-1:0] PULSE_LAST = PULSE_CW'(PULSE_LEN - 1);
  // Unused when DEAD_LEN is 0 because the channel never enters DEAD then.
  localparam logic [PULSE_CW-1:0] DEAD_LAST  = PULSE_CW'(DEAD_LEN - 1);

  pulse_state_t        state, state_n;
  logic [PULSE_CW-1:0] cnt, cnt_n;

  // Next-state, counter and lost-flag decode.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lost    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end
      end
      ACTIVE: begin
        // A request during the pulse, including its final cycle, is dropped.
        lost = req;
        if (cnt == PULSE_LAST) begin
          cnt_n   = '0;
          state_n = (DEAD_LEN == 0) ? IDLE : DEAD;
        end else begin
          cnt_n = cnt + PULSE_CW'(1);
        end
      end
      DEAD: begin
        if (cnt == DEAD_LAST) begin
          // The edge that ends the hold-off is the first one allowed to
          // start the next pulse, so consecutive pulses are exactly
          // PULSE_LEN+DEAD_LEN apart.
          cnt_n   = '0;
          state_n = req ? ACTIVE : IDLE;
        end else begin
          lost  = req;
          cnt_n = cnt + PULSE_CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; outputs follow the next state so
  // they change on the same edge as the FSM.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= (state_n == ACTIVE);
      busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: rtl/output_pulser.sv
// Output pulser top: edge detection on trigger/test inputs, request source
// selection, one pulse_channel per output, and a saturating lost counter.
module output_pulser
  import output_pulser_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PULSE_LEN = 4,
  parameter int DEAD_LEN  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] trig,
  input  logic             enTS,
  input  logic             test_req,
  input  logic [WIDTH-1:0] ts_mask,
  input  logic             lost_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] busy,
  output logic [15:0]      lost_cnt
);

  logic [WIDTH-1:0] trig_d;
  logic             test_d;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] lost;
  logic [16:0]      lost_pop;
  logic [16:0]      lost_sum;

  // Previous-cycle copies for edge detection. They reset high so that a
  // level already asserted when reset releases is not seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d <= '1;
      test_d <= 1'b1;
    end else begin
      trig_d <= trig;
      test_d <= test_req;
    end
  end

  // Request source: trigger edges in normal mode, masked test edge in test mode.
  always_comb begin
    if (enTS) req = {WIDTH{test_req & ~test_d}} & ts_mask;
    else      req = trig & ~trig_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pulse_channel #(
      .PULSE_LEN (PULSE_LEN),
      .DEAD_LEN  (DEAD_LEN)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[i]),
      .q     (Q[i]),
      .busy  (busy[i]),
      .lost  (lost[i])
    );
  end

  // Number of requests dropped this cycle across all channels.
  always_comb begin
    lost_pop = '0;
    for (int i = 0; i < WIDTH; i++) lost_pop = lost_pop + {16'd0, lost[i]};
  end

  assign lost_sum = {1'b0, lost_cnt} + lost_pop;

  // Saturating loss counter; a clear restarts it from this cycle's losses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            lost_cnt <= '0;
    else if (lost_clr)     lost_cnt <= lost_pop[15:0];
    else if (lost_sum[16]) lost_cnt <= LOST_MAX;
    else                   lost_cnt <= lost_sum[15:0];
  end

endmodule

// File: tb/tb_output_pulser.sv
// Self-checking bench for output_pulser: directed scenarios plus randomized
// traffic, all compared against a timeline model of accepted pulses.
module tb_output_pulser;

  localparam int W = 32;
  localparam int P = 4;
  localparam int D = 2;
  // Minimum spacing between accepted requests on one channel.
  localparam int GAP = P + ((D == 0) ? 1 : D);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  trig = '0;
  logic          ents = 1'b0;
  logic          treq = 1'b0;
  logic [W-1:0]  mask = '0;
  logic          clr = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  busy;
  logic [15:0]   lost_cnt;

  int checks = 0;
  int failures = 0;

  // Model: edge index, per-channel accept time and earliest next accept.
  int            e;
  int            m_start[W];
  int            m_next_ok[W];
  logic [W-1:0]  m_prev_trig;
  logic          m_prev_test;
  int            m_lc;
  logic [W-1:0]  exp_q;
  logic [W-1:0]  exp_busy;

  output_pulser #(.WIDTH(W), .PULSE_LEN(P), .DEAD_LEN(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .enTS     (ents),
    .test_req (treq),
    .ts_mask  (mask),
    .lost_clr (clr),
    .Q        (q),
    .busy     (busy),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < W; i++) begin
      m_start[i]   = -1000;
      m_next_ok[i] = 0;
    end
    m_prev_trig = '1;
    m_prev_test = 1'b1;
    m_lc        = 0;
    exp_q       = '0;
    exp_busy    = '0;
  endtask

  // Apply the pulse rules to the inputs sampled on this edge.
  task automatic model_edge();
    int  pop;
    logic r;
    e++;
    pop = 0;
    for (int i = 0; i < W; i++) begin
      r = ents ? (treq & ~m_prev_test & mask[i]) : (trig[i] & ~m_prev_trig[i]);
      if (r) begin
        if (e >= m_next_ok[i]) begin
          m_start[i]   = e;
          m_next_ok[i] = e + GAP;
        end else begin
          pop++;
        end
      end
      exp_q[i]    = (e - m_start[i]) < P;
      exp_busy[i] = (e - m_start[i]) < (P + D);
    end
    m_prev_trig = trig;
    m_prev_test = treq;
    if (clr) m_lc = pop;
    else     m_lc = (m_lc + pop > 65535) ? 65535 : m_lc + pop;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Advance n cycles comparing every output against the model.
  task automatic run_checked(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (q !== exp_q) begin
        failures++;
        $display("FAIL %s q: got %h expected %h at edge %0d", name, q, exp_q, e);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy: got %h expected %h at edge %0d", name, busy, exp_busy, e);
      end
      checks++;
      if (lost_cnt !== 16'(m_lc)) begin
        failures++;
        $display("FAIL %s lost_cnt: got %h expected %h at edge %0d", name, lost_cnt, 16'(m_lc), e);
      end
    end
  endtask

  // Quiesce all channels and zero the loss counter.
  task automatic go_idle();
    trig = '0; ents = 1'b0; treq = 1'b0; clr = 1'b0;
    run_checked(GAP + 2, "idle");
    clr = 1'b1;
    run_checked(1, "idle_clr");
    clr = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (q !== '0 || busy !== '0 || lost_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: q=%h busy=%h lost=%h expected all zero", q, busy, lost_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_checked(3, "post_reset");
  endtask

  task automatic test_single();
    int hi;
    logic [W-1:0] others;
    go_idle();
    hi = 0; others = '0;
    trig[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      run_checked(1, "single");
      if (q[3]) hi++;
      others = others | (q & ~(W'(1) << 3));
    end
    checks++;
    if (hi != P) begin
      failures++;
      $display("FAIL single_width: got %0d high cycles expected %0d", hi, P);
    end
    checks++;
    if (others !== '0) begin
      failures++;
      $display("FAIL single_others: got %h expected 0", others);
    end
    trig[3] = 1'b0;
  endtask

  // Two rising edges on channel 0 separated by 'sep' edges.
  task automatic two_edges(input int sep, input string name, input int exp_pulses,
                           input int exp_lost);
    int rises;
    logic prev;
    go_idle();
    rises = 0; prev = 1'b0;
    for (int k = 0; k < sep + GAP + 4; k++) begin
      trig[0] = (k == 0) || (k == sep);
      run_checked(1, name);
      if (q[0] && !prev) rises++;
      prev = q[0];
    end
    checks++;
    if (rises != exp_pulses) begin
      failures++;
      $display("FAIL %s pulses: got %0d expected %0d", name, rises, exp_pulses);
    end
    checks++;
    if (lost_cnt !== 16'(exp_lost)) begin
      failures++;
      $display("FAIL %s lost: got %0d expected %0d", name, lost_cnt, exp_lost);
    end
  endtask

  task automatic test_all_channels();
    go_idle();
    trig = '1; run_checked(1, "all_rise1");
    trig = '0; run_checked(1, "all_fall");
    trig = '1; run_checked(1, "all_rise2");
    trig = '0; run_checked(GAP + 2, "all_tail");
    checks++;
    if (lost_cnt !== 16'd32) begin
      failures++;
      $display("FAIL all_lost: got %0d expected 32", lost_cnt);
    end
  endtask

  task automatic test_test_mode();
    logic [W-1:0] seen;
    go_idle();
    ents = 1'b1; mask = 32'h0000_00F0;
    run_checked(1, "ts_setup");
    seen = '0;
    for (int k = 0; k < GAP + 6; k++) begin
      treq = (k >= 1 && k <= 3);
      trig = $urandom;
      run_checked(1, "ts_run");
      seen = seen | q;
    end
    checks++;
    if (seen !== 32'h0000_00F0) begin
      failures++;
      $display("FAIL ts_channels: got %h expected 000000f0", seen);
    end
    checks++;
    if (lost_cnt !== 16'd0) begin
      failures++;
      $display("FAIL ts_lost: got %0d expected 0", lost_cnt);
    end
    ents = 1'b0; trig = '0; treq = 1'b0;
  endtask

  task automatic test_random();
    go_idle();
    for (int k = 0; k < 1500; k++) begin
      trig = trig ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 39) == 0) ents = ~ents;
      if ($urandom_range(0, 3) == 0) treq = ~treq;
      if ($urandom_range(0, 19) == 0) mask = $urandom;
      clr = ($urandom_range(0, 31) == 0);
      run_checked(1, "random");
    end
    clr = 1'b0; ents = 1'b0;
  endtask

  task automatic test_saturation();
    go_idle();
    for (int k = 0; k < 7000; k++) begin
      trig = ~trig;
      run_checked(1, "saturate");
    end
    checks++;
    if (lost_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_reached: got %h expected ffff", lost_cnt);
    end
    run_checked(20, "saturate_hold");
    checks++;
    if (lost_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold: got %h expected ffff", lost_cnt);
    end
  endtask

  // Counter is saturated on entry; a clear on a two-loss cycle yields 2.
  task automatic test_clr_two();
    trig = '0;
    run_checked(GAP + 2, "clr_idle");
    trig = 32'h3; run_checked(1, "clr_rise1");
    trig = 32'h0; run_checked(1, "clr_fall");
    trig = 32'h3; clr = 1'b1; run_checked(1, "clr_rise2");
    clr = 1'b0;
    checks++;
    if (lost_cnt !== 16'd2) begin
      failures++;
      $display("FAIL clr_two: got %0d expected 2", lost_cnt);
    end
    trig = '0;
    run_checked(GAP + 2, "clr_tail");
  endtask

  task automatic test_reset_mid();
    go_idle();
    trig[5] = 1'b1;
    run_checked(2, "rm_pulse");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (q !== '0 || busy !== '0 || lost_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: q=%h busy=%h lost=%h expected all zero", q, busy, lost_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_checked(10, "rm_held");
    trig[5] = 1'b0; run_checked(1, "rm_fall");
    trig[5] = 1'b1; run_checked(GAP + 2, "rm_retrig");
    trig = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    two_edges(2, "retrigger", 1, 1);
    two_edges(GAP, "spaced", 2, 0);
    test_all_channels();
    test_test_mode();
    test_random();
    test_saturation();
    test_clr_two();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
